// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults for the time-shared multi-channel sequence detector
package seq_det_pkg;
  localparam int N_CH = 4;
  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b0110;
  localparam int CNT_W = 8;
  localparam int CH_W = $clog2(N_CH);
endpackage

// File: rtl/seq_detect_sched_if.sv
// rtl/seq_detect_sched_if.sv - requester handshake, match status and counter read bundle
interface seq_detect_sched_if #(
  parameter int N_CH  = seq_det_pkg::N_CH,
  parameter int CNT_W = seq_det_pkg::CNT_W,
  parameter int CH_W  = $clog2(N_CH)
);
  logic            en;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] bit_in;
  logic [N_CH-1:0] grant;
  logic            match_valid;
  logic [CH_W-1:0] match_ch;
  logic [CH_W-1:0] rd_ch;
  logic [CNT_W-1:0] rd_cnt;

  modport master (
    output en, req, bit_in, rd_ch,
    input  grant, match_valid, match_ch, rd_cnt
  );

  modport slave (
    input  en, req, bit_in, rd_ch,
    output grant, match_valid, match_ch, rd_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; ptr names the highest-priority channel
module rr_arbiter #(
  parameter int N_CH = seq_det_pkg::N_CH,
  parameter int CH_W = seq_det_pkg::CH_W
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_any
);
  localparam logic [CH_W:0]   N_EXT = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST  = CH_W'(N_CH - 1);

  logic [CH_W-1:0] ptr;
  logic [CH_W:0]   sum;
  logic [CH_W-1:0] cand;

  // Scan from ptr with wrap; one extra bit on sum keeps the modulo exact for any N_CH.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    if (!Reset && en) begin
      for (int k = 0; k < N_CH; k++) begin
        sum = {1'b0, ptr} + (CH_W+1)'(k);
        if (sum >= N_EXT) sum = sum - N_EXT;
        cand = sum[CH_W-1:0];
        if (!grant_any && req[cand]) begin
          grant[cand] = 1'b1;
          grant_idx   = cand;
          grant_any   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + CH_W'(1);
    end
  end
endmodule

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - one shared pattern comparator serving N_CH serial streams round-robin
module seq_detect_sched #(
  parameter int               N_CH    = seq_det_pkg::N_CH,
  parameter int               PAT_W   = seq_det_pkg::PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = seq_det_pkg::PATTERN,
  parameter int               CNT_W   = seq_det_pkg::CNT_W,
  parameter int               CH_W    = $clog2(N_CH)
) (
  input logic               Clock,
  input logic               Reset,
  seq_detect_sched_if.slave bus
);
  localparam int                FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W - 1);
  localparam logic [CH_W:0]     N_EXT  = (CH_W+1)'(N_CH);

  logic [N_CH-1:0]   grant;
  logic [CH_W-1:0]   gidx;
  logic              gany;
  logic [PAT_W-2:0]  hist [N_CH];
  logic [FILL_W-1:0] fill [N_CH];
  logic [CNT_W-1:0]  cnt  [N_CH];
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch;
  logic [CNT_W-1:0]  rd_cnt;

  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .Clock     (Clock),
    .Reset     (Reset),
    .en        (bus.en),
    .req       (bus.req),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_any (gany)
  );

  // The granted channel's history plus its new bit is the only window compared this cycle.
  assign window = {hist[gidx], bus.bit_in[gidx]};
  assign hit    = gany && (fill[gidx] == FULL) && (window == PATTERN);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < N_CH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
        cnt[i]  <= '0;
      end
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= hit;
      if (hit) match_ch <= gidx;
      if (gany) begin
        hist[gidx] <= window[PAT_W-2:0];
        if (fill[gidx] != FULL) fill[gidx] <= fill[gidx] + FILL_W'(1);
        if (hit && (cnt[gidx] != '1)) cnt[gidx] <= cnt[gidx] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    if ({1'b0, bus.rd_ch} < N_EXT) rd_cnt = cnt[bus.rd_ch];
  end

  assign bus.grant       = grant;
  assign bus.match_valid = match_valid;
  assign bus.match_ch    = match_ch;
  assign bus.rd_cnt      = rd_cnt;
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - randomized and directed checks of seq_detect_sched against a queue-based model
module tb_seq_detect_sched;
  import seq_det_pkg::*;

  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detect_sched_if bus ();

  seq_detect_sched dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  int nvec = 0;
  int nerr = 0;

  int m_ptr;
  bit m_q[N_CH][$];
  int m_cnt[N_CH];
  bit exp_mv;
  int exp_mch;

  logic [N_CH-1:0] last_gv;
  bit              last_mv;
  int              last_mch;

  // One cycle: drive, check grant mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step(input bit r, input bit e, input logic [N_CH-1:0] rq,
                      input logic [N_CH-1:0] bits, input int rc);
    int g;
    int c;
    int w;
    bit hit;
    logic [N_CH-1:0] eg;
    int want_cnt;
    rst = r;
    bus.en = e;
    bus.req = rq;
    bus.bit_in = bits;
    bus.rd_ch = CH_W'(rc);
    g = -1;
    if (!r && e) begin
      for (int k = 0; k < N_CH; k++) begin
        c = (m_ptr + k) % N_CH;
        if (g < 0 && ((rq >> c) & 1) != 0) g = c;
      end
    end
    eg = (g >= 0) ? (N_CH'(1) << g) : '0;
    #3;
    nvec++;
    if (bus.grant !== eg) begin
      nerr++;
      $display("FAIL grant: got %b want %b at %0t", bus.grant, eg, $time);
    end
    last_gv = bus.grant;
    hit = 1'b0;
    if (r) begin
      m_ptr = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_q[i].delete();
        m_cnt[i] = 0;
      end
    end else if (g >= 0) begin
      if (m_q[g].size() == PAT_W - 1) begin
        w = 0;
        for (int i = 0; i < PAT_W - 1; i++) w = w * 2 + int'(m_q[g][i]);
        w = w * 2 + (((bits >> g) & 1) != 0 ? 1 : 0);
        hit = (w == int'(PATTERN));
      end
      m_q[g].push_back(((bits >> g) & 1) != 0);
      if (m_q[g].size() > PAT_W - 1) void'(m_q[g].pop_front());
      if (hit) begin
        if (m_cnt[g] < CMAX) m_cnt[g]++;
        exp_mch = g;
      end
      m_ptr = (g + 1) % N_CH;
    end
    exp_mv = hit;
    @(posedge clk);
    #1;
    want_cnt = (rc < N_CH) ? m_cnt[rc] : 0;
    nvec++;
    if (bus.match_valid !== exp_mv) begin
      nerr++;
      $display("FAIL match_valid: got %b want %b at %0t", bus.match_valid, exp_mv, $time);
    end
    if (exp_mv) begin
      nvec++;
      if (bus.match_ch !== CH_W'(exp_mch)) begin
        nerr++;
        $display("FAIL match_ch: got %0d want %0d at %0t", bus.match_ch, exp_mch, $time);
      end
    end
    nvec++;
    if (bus.rd_cnt !== CNT_W'(want_cnt)) begin
      nerr++;
      $display("FAIL rd_cnt[%0d]: got %0d want %0d at %0t", rc, bus.rd_cnt, want_cnt, $time);
    end
    last_mv = bus.match_valid;
    last_mch = int'(bus.match_ch);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, '1, '1, 0);
  endtask

  task automatic feed(input int ch, input int n, input logic [31:0] seq, output int pulses);
    logic [N_CH-1:0] rq;
    pulses = 0;
    rq = N_CH'(1) << ch;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, rq, (((seq >> i) & 1) != 0) ? rq : '0, ch);
      if (last_mv) pulses++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (bus.match_ch !== '0) begin
      nerr++;
      $display("FAIL reset_match_ch: got %0d want 0", bus.match_ch);
    end
    for (int i = 0; i < N_CH; i++) begin
      step(1'b0, 1'b0, '1, '0, i);
      nvec++;
      if (bus.rd_cnt !== '0 || bus.match_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_state[%0d]: rd_cnt %0d mv %b want 0 0", i, bus.rd_cnt, bus.match_valid);
      end
    end
  endtask

  task automatic test_single();
    int p;
    do_reset();
    feed(0, 4, 32'b0110, p);
    nvec++;
    if (p !== 1 || !last_mv || last_mch !== 0 || bus.rd_cnt !== CNT_W'(1)) begin
      nerr++;
      $display("FAIL single: pulses %0d last_mv %b ch %0d cnt %0d want 1 1 0 1", p, last_mv, last_mch, bus.rd_cnt);
    end
  endtask

  task automatic test_fill_guard();
    int p;
    do_reset();
    feed(1, 3, 32'b110, p);
    nvec++;
    if (p !== 0) begin
      nerr++;
      $display("FAIL fill_guard_early: pulses %0d want 0", p);
    end
    feed(1, 4, 32'b0110, p);
    nvec++;
    if (p !== 1 || bus.rd_cnt !== CNT_W'(1)) begin
      nerr++;
      $display("FAIL fill_guard: pulses %0d cnt %0d want 1 1", p, bus.rd_cnt);
    end
  endtask

  task automatic test_overlap();
    int p;
    do_reset();
    feed(2, 7, 32'b0110110, p);
    nvec++;
    if (p !== 2 || bus.rd_cnt !== CNT_W'(2)) begin
      nerr++;
      $display("FAIL overlap: pulses %0d cnt %0d want 2 2", p, bus.rd_cnt);
    end
  endtask

  task automatic test_fairness();
    int order[6] = '{0, 2, 3, 0, 2, 3};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, '1, N_CH'($urandom), 0);
      nvec++;
      if (last_gv !== (N_CH'(1) << (i % 4))) begin
        nerr++;
        $display("FAIL fair_all[%0d]: got %b want ch %0d", i, last_gv, i % 4);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'b1101, N_CH'($urandom), 0);
      nvec++;
      if (last_gv !== (N_CH'(1) << order[i])) begin
        nerr++;
        $display("FAIL fair_skip[%0d]: got %b want ch %0d", i, last_gv, order[i]);
      end
    end
  endtask

  task automatic test_interleave();
    logic [15:0] seq = 16'h6666;
    int i0 = 0;
    int i3 = 0;
    int pulses = 0;
    logic [N_CH-1:0] rq, b;
    do_reset();
    for (int cyc = 0; cyc < 64 && (i0 < 16 || i3 < 16); cyc++) begin
      rq = '0;
      b = '0;
      if (i0 < 16) begin rq[0] = 1'b1; b[0] = seq[15 - i0]; end
      if (i3 < 16) begin rq[3] = 1'b1; b[3] = seq[15 - i3]; end
      step(1'b0, 1'b1, rq, b, 0);
      if (last_gv[0]) i0++;
      if (last_gv[3]) i3++;
      if (last_mv) pulses++;
    end
    nvec++;
    if (pulses !== 8 || i0 !== 16 || i3 !== 16) begin
      nerr++;
      $display("FAIL interleave: pulses %0d bits %0d/%0d want 8 16/16", pulses, i0, i3);
    end
    step(1'b0, 1'b1, '0, '0, 3);
    nvec++;
    if (bus.rd_cnt !== CNT_W'(4)) begin
      nerr++;
      $display("FAIL interleave_cnt3: got %0d want 4", bus.rd_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit mvq[$];
    int mcq[$];
    int n0 = 0;
    int n1 = 0;
    logic [3:0] seq = 4'b0110;
    logic [N_CH-1:0] rq, b;
    do_reset();
    for (int cyc = 0; cyc < 20 && (n0 < 4 || n1 < 4); cyc++) begin
      rq = '0;
      b = '0;
      if (n0 < 4) begin rq[0] = 1'b1; b[0] = seq[3 - n0]; end
      if (n1 < 4) begin rq[1] = 1'b1; b[1] = seq[3 - n1]; end
      step(1'b0, (cyc != 3), rq, b, 1);
      if (last_gv[0]) n0++;
      if (last_gv[1]) n1++;
      mvq.push_back(last_mv);
      mcq.push_back(last_mch);
    end
    nvec++;
    if (mvq.size() != 9 || mvq[7] !== 1'b1 || mvq[8] !== 1'b1 || mcq[7] !== 0 || mcq[8] !== 1) begin
      nerr++;
      $display("FAIL back_to_back: len %0d pulses %b%b ch %0d,%0d want 9 11 0,1", mvq.size(), mvq[$-1], mvq[$], mcq[$-1], mcq[$]);
    end
  endtask

  task automatic test_saturation();
    int p;
    int total;
    do_reset();
    feed(1, 1, 32'b0, p);
    total = 0;
    for (int i = 0; i < 260; i++) begin
      feed(1, 3, 32'b110, p);
      total += p;
    end
    nvec++;
    if (total !== 260 || bus.rd_cnt !== CNT_W'(CMAX)) begin
      nerr++;
      $display("FAIL saturation: pulses %0d cnt %0d want 260 %0d", total, bus.rd_cnt, CMAX);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    do_reset();
    feed(0, 4, 32'b0110, p);
    step(1'b1, 1'b1, 4'b0001, 4'b0000, 0);
    nvec++;
    if (bus.match_valid !== 1'b0 || bus.rd_cnt !== '0) begin
      nerr++;
      $display("FAIL reset_drop: mv %b cnt %0d want 0 0", bus.match_valid, bus.rd_cnt);
    end
    feed(0, 3, 32'b011, p);
    step(1'b1, 1'b1, 4'b0001, 4'b0000, 0);
    feed(0, 1, 32'b0, p);
    nvec++;
    if (p !== 0 || bus.rd_cnt !== '0) begin
      nerr++;
      $display("FAIL reset_mid: pulses %0d cnt %0d want 0 0", p, bus.rd_cnt);
    end
    feed(0, 3, 32'b110, p);
    nvec++;
    if (p !== 1) begin
      nerr++;
      $display("FAIL reset_mid_fill: pulses %0d want 1", p);
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] pend = '0;
    logic [N_CH-1:0] pbit = '0;
    logic [N_CH-1:0] fresh;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fresh = N_CH'($urandom) & ~pend;
      pbit = (pbit & pend) | (N_CH'($urandom) & fresh);
      pend = pend | fresh;
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), pend, pbit,
           $urandom_range(0, N_CH - 1));
      pend = pend & ~last_gv;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req = '0;
    bus.bit_in = '0;
    bus.rd_ch = '0;
    m_ptr = 0;
    exp_mv = 1'b0;
    exp_mch = 0;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill_guard();
    test_overlap();
    test_fairness();
    test_interleave();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Round-robin scheduler that time-shares one serial pattern-detect datapath among `N_CH` independent bit-stream requesters. Per-channel detector history and match statistics live in the scheduler, so one comparator serves all channels. Each channel sees the same behaviour a dedicated `0110` detector would give it. The block sits between the serial input front-ends and the status/interrupt logic.

## Interface

- `N_CH`, 4: number of requesting channels (≥2).
- `PAT_W`, 4: pattern length in bits.
- `PATTERN`, 4'b0110: pattern to detect; MSB is the oldest bit.
- `CNT_W`, 8: width of each per-channel match counter.
- `CH_W`, $clog2(N_CH): channel index width (derived).

Ports:

- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `en`  in  1  scheduler enable; when low, no grants are issued.
- `req`  in  N_CH  channel i has a valid bit on `bit_in[i]`.
- `bit_in`  in  N_CH  serial data bit per channel.
- `grant`  out  N_CH  one-hot or zero; combinational accept of `bit_in[i]` this cycle.
- `match_valid`  out  1  registered pulse: the granted bit completed `PATTERN`.
- `match_ch`  out  CH_W  channel index belonging to `match_valid`.
- `rd_ch`  in  CH_W  counter read select.
- `rd_cnt`  out  CNT_W  combinational read of match counter `rd_ch`.

## Operation

- Handshake: a requester holds `req[i]` and `bit_in[i]` stable until it sees `grant[i]` high. A bit transfers in any cycle where `req[i] & grant[i]`.
- Arbitration: round-robin using pointer `ptr`. `grant` selects the first requesting channel at or after `ptr`, with wrap-around.
  - After each grant, `ptr` becomes (granted index + 1) mod `N_CH`.
  - `ptr` is unchanged in cycles with no grant.
  - At most one grant is issued per cycle.
- `grant` is all-zero whenever `Reset` is high, `en` is low, or `req` is zero.
- Per-channel state:
  - `hist[i]`: `PAT_W-1` most recent bits.
  - `fill[i]`: saturates at `PAT_W-1`.
  - `cnt[i]`: `CNT_W` bits.
- On a grant to channel g:
  - Form `{hist[g], bit_in[g]}` and compare it to `PATTERN`.
  - A hit counts only if `fill[g] == PAT_W-1`.
  - Then `hist[g]` shifts in `bit_in[g]` and `fill[g]` increments, saturating.
- Overlap: history always shifts, so overlapping occurrences are all reported. Example: `0110110` reports 2 matches.
- On a hit, `cnt[g]` increments and saturates at 2^CNT_W−1 (no wrap).
- Non-granted channels' state is untouched.
- Reset values: `ptr`=0, all `hist`=0, all `fill`=0, all `cnt`=0, `match_valid`=0, `match_ch`=0. `grant` is 0 during reset. `rd_cnt` reads 0 after reset.
- Reset mid-operation: a bit presented during the reset cycle is not accepted and not counted. A match pending from the previous cycle's grant is dropped, so `match_valid`=0 after the edge.

## Timing

- Grant latency: 0 cycles. `grant` is valid in the same cycle as `req`, subject to `en` and arbitration.
- For a grant in cycle t:
  - `hist`, `fill` and `ptr` update at the end of t.
  - `match_valid`/`match_ch` are high for exactly cycle t+1.
  - `cnt` is updated at the same edge, so `rd_cnt` shows the new value in t+1.
- Back-to-back matches on different channels in consecutive cycles give consecutive `match_valid` pulses with different `match_ch`.
- `en` falling mid-stream: no grant in that cycle; per-channel state is retained and streams resume unchanged.
- `rd_ch` ≥ `N_CH` returns 0.
- Throughput: 1 bit per cycle in aggregate. Under full load each channel gets 1 bit every `N_CH` cycles.

## Structure

- Package `seq_det_pkg`: default `PATTERN`, `PAT_W`, `N_CH`, `CNT_W`, and the `CH_W` derivation; shared by the scheduler and the benches.
- Sub-module `rr_arbiter` (`N_CH`-wide, inputs `req`/`en`, outputs one-hot `grant` and encoded index, owns `ptr`). The scheduler top holds the history/fill/count arrays and the single shared comparator.

## Test plan

- Single channel 0, `en`=1, feed 0,1,1,0 → `match_valid`=1 with `match_ch`=0 in the cycle after the 4th grant; `rd_cnt`(0)=1.
- Fill guard: right after reset, channel 1 feeds 1,1,0 → no match (zeroed history must not complete `0110`). Continuing with 0,1,1,0 → exactly one match.
- Overlap: channel 2 feeds 0,1,1,0,1,1,0 → 2 matches; `cnt[2]`=2.
- Fairness: `req`=4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3. Dropping `req[1]` → grants skip 1, order 0,2,3.
- Interleave plus saturation (`CNT_W`=2): channels 0 and 3 each send `0110` four times, interleaved → the streams are detected independently; both counters saturate at 3 and 8 `match_valid` pulses occur.
- Reset mid-stream: channel 0 sends 0,1,1, then `Reset` is high for 1 cycle, then 0 → no match, `fill[0]`=1 afterwards, `grant`=0 during the reset cycle, all counters 0.
